// File: rtl/rv32i_pkg.sv
// Shared integer-core definitions: register file geometry and the writeback entry type.
package rv32i_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order queue with same-cycle push/pop; a push into a full queue is taken
// only when a pop frees the slot in the same cycle.
module wb_fifo
    import rv32i_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_entry_t
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rptr];

    // NOTE: storage is deliberately not reset; the pointers and count alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rd_writeback.sv
// Register-file writeback port: round-robin ALU/LSU arbitration, in-order queue and RAW scoreboard.
// Optional forwarding outputs are enabled with `define RD_WRITEBACK_BYPASS_EN.
module rd_writeback
    import rv32i_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CNTW  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_lsu_valid,
    output logic                  o_lsu_ready,
    input  logic [REG_ADDR_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]       i_lsu_data,
    input  logic                  i_stall,
    output logic                  o_rd_wvalid,
    output logic [REG_ADDR_W-1:0] o_rd_waddr,
    output logic [XLEN-1:0]       o_rd_wdata,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    output logic [NUM_REGS-1:0]   o_busy
`ifdef RD_WRITEBACK_BYPASS_EN
    ,
    output logic                  o_fwd_valid,
    output logic [REG_ADDR_W-1:0] o_fwd_rd,
    output logic [XLEN-1:0]       o_fwd_data,
    output logic [NUM_REGS-1:0]   o_busy_nofwd
`endif
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;

    logic                  r_run;
    logic                  r_prefer_alu;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]       r_wdata;
    logic [CNTW-1:0]       r_cnt [NUM_REGS];

    logic   w_full;
    logic   w_empty;
    logic   w_pop;
    logic   w_space;
    logic   w_grant_alu;
    logic   w_grant_lsu;
    logic   w_push;
    entry_t w_push_entry;
    entry_t w_head;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_inc_ovf;
    logic                w_dec_unf;

    // Readys stay low until the first edge after reset release.
    assign w_pop       = !w_empty && !i_stall;
    assign w_space     = r_run && (!w_full || w_pop);
    assign w_grant_alu = w_space && i_alu_valid && (!i_lsu_valid || r_prefer_alu);
    assign w_grant_lsu = w_space && i_lsu_valid && !w_grant_alu;
    assign o_alu_ready = w_grant_alu;
    assign o_lsu_ready = w_grant_lsu;

    assign w_push_entry = w_grant_alu ? entry_t'{rd: i_alu_rd, data: i_alu_data}
                                      : entry_t'{rd: i_lsu_rd, data: i_lsu_data};
    assign w_push       = (w_grant_alu && i_alu_rd != '0) || (w_grant_lsu && i_lsu_rd != '0);

    wb_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run        <= 1'b0;
            r_prefer_alu <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_grant_alu)      r_prefer_alu <= 1'b0;
            else if (w_grant_lsu) r_prefer_alu <= 1'b1;
            if (w_pop) begin
                r_waddr <= w_head.rd;
                r_wdata <= w_head.data;
            end
        end
    end

    assign o_rd_wvalid = w_pop;
    assign o_rd_waddr  = w_pop ? w_head.rd   : r_waddr;
    assign o_rd_wdata  = w_pop ? w_head.data : r_wdata;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_inc     = '0;
        w_dec     = '0;
        w_inc_ovf = 1'b0;
        w_dec_unf = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_inc[i]  = i_issue_valid && (i_issue_rd == REG_ADDR_W'(i));
            w_dec[i]  = w_pop && (w_head.rd == REG_ADDR_W'(i));
            w_inc_ovf = w_inc_ovf || (w_inc[i] && !w_dec[i] && r_cnt[i] == '1);
            w_dec_unf = w_dec_unf || (w_dec[i] && !w_inc[i] && r_cnt[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i] && r_cnt[i] != '1)
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        o_busy = '0;
        for (int i = 1; i < NUM_REGS; i++) o_busy[i] = (r_cnt[i] != '0);
    end

`ifdef RD_WRITEBACK_BYPASS_EN
    assign o_fwd_valid = !w_empty;
    assign o_fwd_rd    = w_head.rd;
    assign o_fwd_data  = w_head.data;

    always_comb begin
        o_busy_nofwd = o_busy;
        if (!w_empty && r_cnt[w_head.rd] == CNTW'(1)) o_busy_nofwd[w_head.rd] = 1'b0;
    end
`endif

`ifndef SYNTHESIS
    a_cnt_overflow:  assert property (@(posedge clk) disable iff (!rstn) !w_inc_ovf);
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!rstn) !w_dec_unf);
`endif

endmodule

// File: tb/tb_rd_writeback.sv
// Self-checking bench for rd_writeback: directed scenarios plus random traffic,
// with a queue-based scoreboard checked by an independent write-port monitor.
module tb_rd_writeback;

    localparam int DEPTH   = 2;
    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_alu_valid, i_lsu_valid, i_stall, i_issue_valid;
    logic        o_alu_ready, o_lsu_ready, o_rd_wvalid;
    logic [4:0]  i_alu_rd, i_lsu_rd, i_issue_rd, o_rd_waddr;
    logic [31:0] i_alu_data, i_lsu_data, o_rd_wdata, o_busy;
`ifdef RD_WRITEBACK_BYPASS_EN
    logic        o_fwd_valid;
    logic [4:0]  o_fwd_rd;
    logic [31:0] o_fwd_data, o_busy_nofwd;
`endif

    rd_writeback #(.XLEN(32), .DEPTH(DEPTH), .CNTW(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_alu_valid   (i_alu_valid),
        .o_alu_ready   (o_alu_ready),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .i_lsu_valid   (i_lsu_valid),
        .o_lsu_ready   (o_lsu_ready),
        .i_lsu_rd      (i_lsu_rd),
        .i_lsu_data    (i_lsu_data),
        .i_stall       (i_stall),
        .o_rd_wvalid   (o_rd_wvalid),
        .o_rd_waddr    (o_rd_waddr),
        .o_rd_wdata    (o_rd_wdata),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_busy        (o_busy)
`ifdef RD_WRITEBACK_BYPASS_EN
        ,
        .o_fwd_valid   (o_fwd_valid),
        .o_fwd_rd      (o_fwd_rd),
        .o_fwd_data    (o_fwd_data),
        .o_busy_nofwd  (o_busy_nofwd)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];    // scoreboard: writes the port must still produce, in order
    wr_t model_q[$];  // reference model's view of the queue contents
    int  cnt_m [32];  // reference pending-write count per register
    bit  last_lsu;    // reference: the most recent grant went to the LSU
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] busy_model();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (cnt_m[i] != 0);
        return b;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        model_q.delete();
        for (int i = 0; i < 32; i++) cnt_m[i] = 0;
        last_lsu = 1'b0;
    endtask

    // One clock cycle: entered at posedge+1, drives inputs, checks the predicted
    // handshake/busy state, advances the model, and returns at the next posedge+1.
    task automatic step(input bit av, input int ard, input logic [31:0] ad,
                        input bit lv, input int lrd, input logic [31:0] ld,
                        input bit st, input bit iv, input int ird,
                        output bit ga, output bit gl);
        bit  pop, space;
        wr_t e;
        i_alu_valid   = av;  i_alu_rd = 5'(ard); i_alu_data = ad;
        i_lsu_valid   = lv;  i_lsu_rd = 5'(lrd); i_lsu_data = ld;
        i_stall       = st;
        i_issue_valid = iv;  i_issue_rd = 5'(ird);
        #1;
        pop   = (model_q.size() > 0) && !st;
        space = (model_q.size() < DEPTH) || pop;
        ga    = space && av && (!lv || last_lsu);
        gl    = space && lv && !ga;
        check("alu_ready", 64'(o_alu_ready), 64'(ga));
        check("lsu_ready", 64'(o_lsu_ready), 64'(gl));
        check("wvalid",    64'(o_rd_wvalid), 64'(pop));
        check("busy",      64'(o_busy),      64'(busy_model()));
        if (pop) begin
            e = model_q.pop_front();
            cnt_m[e.rd]--;
        end
        if (iv && ird != 0) cnt_m[ird]++;
        if (ga) begin
            last_lsu = 1'b0;
            if (ard != 0) begin
                e.rd = ard; e.data = ad;
                model_q.push_back(e); exp_q.push_back(e);
            end
        end
        if (gl) begin
            last_lsu = 1'b1;
            if (lrd != 0) begin
                e.rd = lrd; e.data = ld;
                model_q.push_back(e); exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit ga, gl;
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
    endtask

    task automatic issue(input int rd);
        bit ga, gl;
        step(0, 0, 0, 0, 0, 0, 0, 1, rd, ga, gl);
    endtask

    // Write-port monitor: every strobe must match the oldest outstanding accepted result.
    always @(negedge clk) begin
        if (rstn && o_rd_wvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(o_rd_waddr), 64'(0));
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("waddr", 64'(o_rd_waddr), 64'(e.rd));
                check("wdata", 64'(o_rd_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ga, gl;
        bit          a_v, l_v, st, iv;
        int          a_rd, l_rd, ird, guard;
        logic [31:0] a_d, l_d;
        int          pool[$];

        model_clear();
        rstn = 1'b0;
        i_alu_valid = 1'b1; i_lsu_valid = 1'b1; i_stall = 1'b0; i_issue_valid = 1'b0;
        i_alu_rd = 5'd1; i_lsu_rd = 5'd2; i_alu_data = '0; i_lsu_data = '0; i_issue_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wvalid",    64'(o_rd_wvalid), 64'(0));
        check("rst_waddr",     64'(o_rd_waddr),  64'(0));
        check("rst_wdata",     64'(o_rd_wdata),  64'(0));
        check("rst_busy",      64'(o_busy),      64'(0));
        check("rst_alu_ready", 64'(o_alu_ready), 64'(0));
        check("rst_lsu_ready", 64'(o_lsu_ready), 64'(0));
        i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single ALU write: visible in the cycle after acceptance only.
        issue(5);
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, ga, gl);
        idle(2);

        // Both sources held valid: grants alternate starting with the LSU.
        issue(3); issue(3); issue(4); issue(4);
        for (int k = 0; k < 4; k++) step(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, ga, gl);
        idle(2);

        // x0 result is handshaken and dropped.
        step(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, ga, gl);
        check("x0_busy0", 64'(o_busy[0]), 64'(0));
        idle(1);

        // Backpressure: two accepted under stall, third waits for the first pop.
        issue(7); issue(8); issue(9);
        step(1, 7, 32'h7, 0, 0, 0, 1, 0, 0, ga, gl);
        step(1, 8, 32'h8, 0, 0, 0, 1, 0, 0, ga, gl);
        step(1, 9, 32'h9, 0, 0, 0, 1, 0, 0, ga, gl);
        step(1, 9, 32'h9, 0, 0, 0, 1, 0, 0, ga, gl);
        step(1, 9, 32'h9, 0, 0, 0, 0, 0, 0, ga, gl);
        check("full_passthrough_grant", 64'(ga), 64'(1));
        idle(3);

        // Scoreboard: commit coinciding with a re-issue keeps rd 10 busy.
        issue(10); issue(10);
        step(1, 10, 32'hA, 0, 0, 0, 0, 0, 0, ga, gl);
        step(1, 10, 32'hB, 0, 0, 0, 0, 0, 0, ga, gl);
        step(0, 0, 0, 0, 0, 0, 0, 1, 10, ga, gl);
        check("busy10_held", 64'(o_busy[10]), 64'(1));
        step(1, 10, 32'hC, 0, 0, 0, 0, 0, 0, ga, gl);
        idle(2);
        check("busy10_clear", 64'(o_busy[10]), 64'(0));

        // Random traffic: results only for issued registers, offers held until accepted.
        a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_d = '0; l_d = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!a_v && pool.size() > 0 && $urandom_range(0, 3) != 0) begin
                a_v = 1; a_rd = pool.pop_front(); a_d = $urandom;
            end else if (!a_v && $urandom_range(0, 15) == 0) begin
                a_v = 1; a_rd = 0; a_d = $urandom;
            end
            if (!l_v && pool.size() > 0 && $urandom_range(0, 3) != 0) begin
                l_v = 1; l_rd = pool.pop_front(); l_d = $urandom;
            end else if (!l_v && $urandom_range(0, 15) == 0) begin
                l_v = 1; l_rd = 0; l_d = $urandom;
            end
            st  = ($urandom_range(0, 3) == 0);
            ird = $urandom_range(1, 31);
            iv  = ($urandom_range(0, 1) == 1) && (cnt_m[ird] < CNT_MAX);
            step(a_v, a_rd, a_d, l_v, l_rd, l_d, st, iv, ird, ga, gl);
            if (ga) a_v = 0;
            if (gl) l_v = 0;
            if (iv) pool.push_back(ird);
        end
        guard = 0;
        while ((a_v || l_v || model_q.size() > 0) && guard < 50) begin
            step(a_v, a_rd, a_d, l_v, l_rd, l_d, 0, 0, 0, ga, gl);
            if (ga) a_v = 0;
            if (gl) l_v = 0;
            guard++;
        end
        check("random_drain_timeout", 64'(guard < 50), 64'(1));
        idle(1);

        // Asynchronous reset with two entries queued.
        issue(20); issue(21);
        step(1, 20, 32'h20, 0, 0, 0, 1, 0, 0, ga, gl);
        step(1, 21, 32'h21, 0, 0, 0, 1, 0, 0, ga, gl);
        i_alu_valid = 0; i_stall = 0;
        #1;
        check("pre_reset_wvalid", 64'(o_rd_wvalid), 64'(1));
        #1;
        rstn = 1'b0;
        #1;
        check("async_rst_wvalid", 64'(o_rd_wvalid), 64'(0));
        check("async_rst_busy",   64'(o_busy),      64'(0));
        model_clear();
        @(posedge clk);
        #3;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle(1);
        issue(6); issue(7);
        step(1, 6, 32'h66, 1, 7, 32'h77, 0, 0, 0, ga, gl);
        check("post_rst_lsu_first", 64'(gl), 64'(1));
        step(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, ga, gl);
        idle(3);

        @(negedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_writeback.md
Name: rd_writeback

Overview:
- Writer side of the integer register file write port.
- Collects completed results from the ALU and the load/store unit over valid/ready handshakes and arbitrates between them round-robin.
- Buffers winners in a small in-order queue and drives one register write per cycle (wvalid/waddr/wdata).
- Keeps a per-register pending scoreboard so issue logic can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of results and register write data.
- DEPTH, 2, writeback queue entries; power of two, minimum 2.
- CNTW, 2, width of each per-register pending counter; max outstanding writes per register = 2^CNTW-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- i_alu_valid  in  1  ALU result valid.
- o_alu_ready  out  1  ALU result accepted this cycle when valid.
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  XLEN  ALU result.
- i_lsu_valid  in  1  load result valid.
- o_lsu_ready  out  1  load result accepted this cycle when valid.
- i_lsu_rd  in  5  load destination register.
- i_lsu_data  in  XLEN  load result.
- i_stall  in  1  blocks queue pop (write port borrowed elsewhere).
- o_rd_wvalid  out  1  register write strobe.
- o_rd_waddr  out  5  register write address.
- o_rd_wdata  out  XLEN  register write data.
- i_issue_valid  in  1  instruction issued with a destination register.
- i_issue_rd  in  5  issued destination register.
- o_busy  out  32  bit i set while register i has a pending write; bit 0 always 0.

Behaviour:
- Reset (async, rstn low): queue empty; all pending counters 0; round-robin pointer favours LSU. Outputs: o_rd_wvalid=0, o_rd_waddr=0, o_rd_wdata=0, o_busy=0, both readys=0.
- Readys: at most one source granted per cycle.
  - Grant requires valid and (queue not full, or a pop this cycle).
  - Both sources valid: grant the one not granted last; pointer updates only on an actual grant.
  - ready = grant; ready is never asserted to a non-valid source.
- Enqueue: accepted result with rd != 0 is pushed {rd, data}. rd == 0 is accepted and discarded (handshake completes, no push, no write).
- Pop: queue non-empty and i_stall=0.
  - o_rd_wvalid=1, o_rd_waddr/o_rd_wdata = head entry (driven from flops; no combinational path from source inputs).
  - Otherwise o_rd_wvalid=0 and addr/data hold last values.
- Latency: accepted at edge N, write visible on o_rd_* in cycle N+1 when queue was empty and unstalled.
- Ordering: strict FIFO; same-rd writes are committed in acceptance order.
- Full with simultaneous pop: push allowed in the same cycle (pass-through occupancy).
- Scoreboard:
  - i_issue_valid with rd != 0 increments cnt[rd].
  - Pop of rd decrements cnt[rd].
  - Same-cycle increment and decrement on the same rd leaves it unchanged.
  - o_busy[i] = (cnt[i] != 0), registered value.
  - Increment at max and decrement at 0 are protocol errors: counter saturates/holds, simulation assertion fires.
- i_stall held: queue fills to DEPTH, then both readys drop; scoreboard unaffected.

Optional Feature:
- Macro RD_WRITEBACK_BYPASS_EN.
- Defined:
  - Adds ports o_fwd_valid (1), o_fwd_rd (5), o_fwd_data (XLEN), mirroring the current queue head whenever the queue is non-empty, regardless of i_stall.
  - Adds o_busy_nofwd (32): o_busy with the head rd bit cleared when that rd's count == 1.
- Undefined: ports absent, no extra logic.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN default, REG_ADDR_W=5, NUM_REGS=32.
  - typedef wb_entry_t struct {rd, data}.
- Sub-module wb_fifo: parameterised by DEPTH and entry type, with push/pop/full/empty and simultaneous push-pop. Arbiter and scoreboard stay in rd_writeback.

Test Plan:
- Reset mid-traffic: 2 queued entries, rstn low asynchronously between edges -> o_rd_wvalid=0 immediately, o_busy=0, queue empty after release.
- Single ALU write rd=5, data=0xDEADBEEF at edge N -> o_rd_wvalid=1, waddr=5, wdata=0xDEADBEEF in cycle N+1 only.
- ALU rd=3/0x11 and LSU rd=4/0x22 held valid together for 4 cycles -> grants alternate LSU, ALU, LSU, ALU; writes emerge in grant order.
- x0 discard: LSU rd=0 data=0xFFFFFFFF -> o_lsu_ready=1, no o_rd_wvalid, o_busy[0]=0.
- Stall/backpressure: i_stall=1, three ALU results rd=7,8,9 offered -> first 2 accepted, ready low on third; i_stall drop -> writes 7, 8, then 9 accepted, all in order.
- Scoreboard: issue rd=10 twice, then commit two rd=10 writes (second commit same cycle as a new issue of rd=10) -> o_busy[10] stays 1 until a final commit with no concurrent issue clears it.
